// File: rtl/fns_dec_sched.sv
// fns_dec_sched: four requesters share one Fibonacci-number-system decoder.
//   A round-robin arbiter accepts at most one 12-bit codeword per cycle. The
//   codeword is decoded (sum of Fibonacci weights of its set bits) and
//   presented on a valid/ready output stage that also counts completed
//   output transfers.
//
// Optional feature: define FNS_DEC_SCHED_PIPE_EN to add a register stage
//   (code, id, valid) in front of the decoder. Latency grows from 1 to 2
//   cycles and throughput stays at one result per cycle.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid[3:0]    requester i has a codeword pending
//   req_code[47:0]    codeword of requester i at [12*i +: 12]
//   req_ready[3:0]    zero-or-one-hot accept, combinational
//   out_valid         decoded result available
//   out_data          decoded value, `FBLEN12 bits wide
//   out_id[1:0]       requester that supplied out_data
//   out_ready         consumer accepts the result
//   dec_count[15:0]   completed output transfers, saturating

`ifndef FBLEN12
`define FBLEN12 10
`endif

module fns_dec_sched (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [3:0]          req_valid,
    input  logic [47:0]         req_code,
    output logic [3:0]          req_ready,
    output logic                out_valid,
    output logic [`FBLEN12-1:0] out_data,
    output logic [1:0]          out_id,
    input  logic                out_ready,
    output logic [15:0]         dec_count
);

    localparam int DW = `FBLEN12;

    // Weights W01..W12 for code bits 0..11.
    localparam logic [DW-1:0] FIB_W [12] = '{
        DW'(1),  DW'(2),  DW'(3),   DW'(5),   DW'(8),   DW'(13),
        DW'(21), DW'(34), DW'(55),  DW'(89),  DW'(144), DW'(233)
    };

    function automatic logic [DW-1:0] fns_decode(input logic [11:0] code);
        logic [DW-1:0] acc;
        acc = '0;
        for (int k = 0; k < 12; k++) begin
            if (code[k]) acc = acc + FIB_W[k];
        end
        return acc;
    endfunction

    logic [3:0][11:0] codes;
    assign codes = req_code;

    logic [1:0]    last_grant_q, last_grant_d;
    logic          out_valid_q,  out_valid_d;
    logic [DW-1:0] out_data_q,   out_data_d;
    logic [1:0]    out_id_q,     out_id_d;
    logic [15:0]   dec_count_q,  dec_count_d;

    logic [1:0]    grant_id;
    logic          grant_found;
    logic          out_free;
    logic          in_free;
    logic          accept;
    logic          drain;
    logic [11:0]   dec_in;
    logic [DW-1:0] dec_out;

`ifdef FNS_DEC_SCHED_PIPE_EN
    logic          s1_valid_q, s1_valid_d;
    logic [11:0]   s1_code_q,  s1_code_d;
    logic [1:0]    s1_id_q,    s1_id_d;
    logic          s1_adv;
`endif

    // Round-robin search starting one past the last accepted requester.
    // An offset of 4 wraps back onto last_grant itself (checked last).
    always_comb begin
        grant_id    = last_grant_q;
        grant_found = 1'b0;
        for (int off = 1; off <= 4; off++) begin
            logic [1:0] idx;
            idx = last_grant_q + 2'(off);
            if (!grant_found && req_valid[idx]) begin
                grant_found = 1'b1;
                grant_id    = idx;
            end
        end
    end

    assign drain    = out_valid_q & out_ready;
    assign out_free = ~out_valid_q | out_ready;

`ifdef FNS_DEC_SCHED_PIPE_EN
    // Stage 1 moves forward whenever the output stage can take it.
    assign s1_adv  = s1_valid_q & out_free;
    assign in_free = ~s1_valid_q | out_free;
    assign dec_in  = s1_code_q;
`else
    assign in_free = out_free;
    assign dec_in  = codes[grant_id];
`endif

    // rst_n gates the grant so nothing is offered while in reset.
    always_comb begin
        req_ready = '0;
        if (rst_n && in_free && grant_found) req_ready[grant_id] = 1'b1;
    end

    assign accept  = |(req_valid & req_ready);
    assign dec_out = fns_decode(dec_in);

    always_comb begin
        last_grant_d = last_grant_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_id_d     = out_id_q;
        dec_count_d  = dec_count_q;

        if (accept) last_grant_d = grant_id;
        if (drain && dec_count_q != 16'hFFFF) dec_count_d = dec_count_q + 16'd1;

`ifdef FNS_DEC_SCHED_PIPE_EN
        s1_valid_d = s1_valid_q;
        s1_code_d  = s1_code_q;
        s1_id_d    = s1_id_q;

        if (accept) begin
            s1_valid_d = 1'b1;
            s1_code_d  = codes[grant_id];
            s1_id_d    = grant_id;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
        end

        if (s1_adv) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_out;
            out_id_d    = s1_id_q;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
`else
        // Load on accept even when draining, so back-to-back results have no bubble.
        if (accept) begin
            out_valid_d = 1'b1;
            out_data_d  = dec_out;
            out_id_d    = grant_id;
        end else if (drain) begin
            out_valid_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 2'd3;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_id_q     <= '0;
            dec_count_q  <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_id_q     <= out_id_d;
            dec_count_q  <= dec_count_d;
        end
    end

`ifdef FNS_DEC_SCHED_PIPE_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_code_q  <= '0;
            s1_id_q    <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_code_q  <= s1_code_d;
            s1_id_q    <= s1_id_d;
        end
    end
`endif

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_id    = out_id_q;
    assign dec_count = dec_count_q;

endmodule

// File: tb/tb_fns_dec_sched.sv
// Directed testbench for fns_dec_sched with a scoreboard: every accepted
// request pushes its hand-computed {id, data} into a queue, and a monitor
// thread pops and compares on every output transfer.

`ifndef FBLEN12
`define FBLEN12 10
`endif

module tb_fns_dec_sched;

    localparam int DW = `FBLEN12;
`ifdef FNS_DEC_SCHED_PIPE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    req_valid;
    logic [47:0]   req_code;
    logic [3:0]    req_ready;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic [1:0]    out_id;
    logic          out_ready;
    logic [15:0]   dec_count;

    int checks   = 0;
    int failures = 0;
    logic [DW+1:0] exp_q [$];
    logic [DW+1:0] exp_e;

    always #5 clk = ~clk;

    fns_dec_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_code  (req_code),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .out_ready (out_ready),
        .dec_count (dec_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Check the grant offered this cycle; if one is expected, record the result it must yield.
    task automatic xfer(input logic [3:0] exp_rdy, input logic [1:0] id, input logic [DW-1:0] d);
        @(negedge clk);
        chk("req_ready", 32'(req_ready), 32'(exp_rdy));
        if (exp_rdy != 4'b0000) exp_q.push_back({id, d});
        tick();
    endtask

    task automatic do_reset();
        tick();
        rst_n = 1'b0;
        exp_q.delete();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 4'hF;
        req_code  = '0;
        out_ready = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && out_valid && out_ready) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected got id=%0d data=%0d required no output", out_id, out_data);
                    end else begin
                        exp_e = exp_q.pop_front();
                        if ({out_id, out_data} !== exp_e) begin
                            failures++;
                            $display("FAIL sb_result got id=%0d data=%0d required id=%0d data=%0d",
                                     out_id, out_data, exp_e[DW+1:DW], exp_e[DW-1:0]);
                        end
                    end
                end
            end
        join_none

        // Reset state
        #3;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_data",  32'(out_data), 0);
        chk("rst_out_id",    32'(out_id), 0);
        chk("rst_dec_count", 32'(dec_count), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        tick();
        rst_n = 1'b1;

        // Single transfer and latency
        req_valid = 4'b0001;
        req_code[11:0] = 12'h001;
        out_ready = 1'b1;
        xfer(4'b0001, 2'd0, 1);
        req_valid = 4'b0000;
        repeat (LAT - 1) tick();
        @(negedge clk);
        chk("lat_out_valid", 32'(out_valid), 1);
        tick();
        @(negedge clk);
        chk("lat_dec_count", 32'(dec_count), 1);

        // Round robin across all four, back to back
        do_reset();
        req_code  = {12'h000, 12'hAAA, 12'h005, 12'h800};
        req_valid = 4'b1111;
        xfer(4'b0001, 2'd0, 233);
        req_valid = 4'b1110;
        xfer(4'b0010, 2'd1, 4);
        req_valid = 4'b1100;
        xfer(4'b0100, 2'd2, 376);
        req_valid = 4'b1000;
        xfer(4'b1000, 2'd3, 0);
        req_valid = 4'b0000;
        xfer(4'b0000, 2'd0, 0);
        repeat (4) tick();
        chk("rr_sb_empty", 32'(exp_q.size()), 0);
        chk("rr_dec_count", 32'(dec_count), 4);

        // Back-pressure: stall, hold output stable, then drain+accept together
        out_ready = 1'b0;
        req_code[23:12] = 12'h003;
        req_valid = 4'b0010;
        xfer(4'b0010, 2'd1, 3);
        req_code[23:12] = 12'h010;
`ifdef FNS_DEC_SCHED_PIPE_EN
        xfer(4'b0010, 2'd1, 8);
        req_code[23:12] = 12'h100;
`endif
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_req_ready", 32'(req_ready), 0);
            chk("stall_out_valid", 32'(out_valid), 1);
            chk("stall_out_data",  32'(out_data), 3);
            chk("stall_out_id",    32'(out_id), 1);
            tick();
        end
        out_ready = 1'b1;
`ifdef FNS_DEC_SCHED_PIPE_EN
        xfer(4'b0010, 2'd1, 55);
`else
        xfer(4'b0010, 2'd1, 8);
`endif
        req_valid = 4'b0000;
        @(negedge clk);
        chk("nobubble_out_valid", 32'(out_valid), 1);
        repeat (4) tick();
        chk("bp_sb_empty", 32'(exp_q.size()), 0);

        // Reset while a result is in flight
        out_ready = 1'b0;
        req_code[11:0] = 12'h001;
        req_valid = 4'b0001;
        xfer(4'b0001, 2'd0, 1);
        req_valid = 4'b1111;
        tick();
        @(posedge clk); #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 0);
        chk("mid_rst_dec_count", 32'(dec_count), 0);
        chk("mid_rst_req_ready", 32'(req_ready), 0);
        tick();
        rst_n     = 1'b1;
        req_valid = 4'b0000;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(out_valid), 0);
            tick();
        end
        req_code  = {12'h001, 12'h001, 12'h001, 12'h002};
        req_valid = 4'b1111;
        xfer(4'b0001, 2'd0, 2);
        req_valid = 4'b0000;
        repeat (4) tick();
        chk("rst_sb_empty", 32'(exp_q.size()), 0);

        // Round-robin wrap: last grant 2, next candidates 3 then 0
        req_code[35:24] = 12'h002;
        req_code[11:0]  = 12'h040;
        req_valid = 4'b0100;
        repeat (3) xfer(4'b0100, 2'd2, 2);
        req_valid = 4'b0101;
        xfer(4'b0001, 2'd0, 21);
        req_valid = 4'b0100;
        xfer(4'b0100, 2'd2, 2);
        req_valid = 4'b0000;
        repeat (4) tick();
        chk("wrap_sb_empty", 32'(exp_q.size()), 0);

        // Saturating transfer counter
        do_reset();
        req_code[11:0] = 12'h001;
        req_valid = 4'b0001;
        out_ready = 1'b1;
        for (int i = 0; i < 65540; i++) xfer(4'b0001, 2'd0, 1);
        req_valid = 4'b0000;
        repeat (4) tick();
        @(negedge clk);
        chk("sat_dec_count", 32'(dec_count), 32'h0000FFFF);
        chk("sat_sb_empty", 32'(exp_q.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
